dmem_responder: RTL and testbench

Data-memory responder serving load/store requests issued by the pipelined core's MEM stage.
- Word-organised storage behind a valid/ready request channel and a valid/ready response channel.
- Programmable access latency, so the pipeline can be exercised against a non-ideal memory.
- One outstanding request at a time; out-of-range and misaligned accesses are flagged as errors.

---
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory for the core's MEM stage: one request in flight, response LATENCY edges after accept.
// Request side stalls (req_ready low) from accept until the response handshake; response is held until rsp_ready.
module dmem_responder #(
  parameter int DEPTH   = 40,
  parameter int LATENCY = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  // Power-up image (a sampled parabola in words 0..20); reset deliberately leaves it alone.
  logic [DATA_W-1:0] mem [DEPTH] = '{
    1: 19, 2: 36, 3: 51, 4: 64, 5: 75, 6: 84, 7: 91, 8: 96, 9: 99, 10: 100,
    11: 99, 12: 96, 13: 91, 14: 84, 15: 75, 16: 64, 17: 51, 18: 36, 19: 19,
    default: '0
  };

  logic [ADDR_W-3:0] word_idx;
  logic              addr_err;

  logic              wr_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              access;
  logic              handshake;

  assign word_idx = req_addr[ADDR_W-1:2];
  assign addr_err = (req_addr[1:0] != 2'b00) || (word_idx >= (ADDR_W-2)'(DEPTH));

  assign accept    = (state == IDLE) && req_valid;
  assign access    = (state == WAIT) && (cnt == '0);
  assign handshake = (state == RESP) && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        err_q   <= addr_err;
        idx_q   <= word_idx[IDX_W-1:0];
        wdata_q <= req_wdata;
        cnt     <= CNT_W'(LATENCY - 1);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end

      // rsp_rdata is only ever written at the access edge, so it survives the handshake.
      if (access) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err_q;
        rsp_rdata <= (!wr_q && !err_q) ? mem[idx_q] : '0;
      end else if (handshake) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Gated by reset so a store caught mid-flight by reset never lands.
  always_ff @(posedge clk) begin
    if (access && wr_q && !err_q && !reset) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a word-array reference model.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int DEPTH = 40;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        req_valid_b, req_ready_b, req_write_b;
  logic [31:0] req_addr_b, req_wdata_b;
  logic        rsp_valid_b, rsp_ready_b, rsp_err_b, busy_b;
  logic [31:0] rsp_rdata_b;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1), .DATA_W(32), .ADDR_W(32)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
    .rsp_err(rsp_err_b), .busy(busy_b)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] ref_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic ref_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
  endfunction

  // Entered just after a negedge; leaves just after the negedge following the handshake.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, input bit chain);
    logic        err_e;
    logic [31:0] rd_e;
    int          n;
    err_e = ref_err(addr);
    rd_e  = (!wr && !err_e) ? ref_mem[int'(addr >> 2)] : 32'd0;
    if (wr && !err_e) ref_mem[int'(addr >> 2)] = wd;

    check("req_ready_idle", 32'(req_ready), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 20) begin
      check("req_ready_wait", 32'(req_ready), 32'd0);
      check("busy_wait", 32'(busy), 32'd1);
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      @(negedge clk);
      n++;
    end
    check("latency", n, LAT);
    if (chain) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd8;
    end else begin
      req_valid = 1'b0;
    end
    check("rdata", rsp_rdata, rd_e);
    check("err", 32'(rsp_err), 32'(err_e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, rd_e);
      check("hold_err", 32'(rsp_err), 32'(err_e));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_err", 32'(rsp_err), 32'd0);
    check("post_rdata", rsp_rdata, rd_e);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int          acc[$];
    int          rsp_at[$];
    logic [31:0] rsp_dat[$];
    logic        acc_now;
    logic [31:0] a;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i <= 20) ? 32'(i * (20 - i)) : 32'd0;

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; rsp_ready_b = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_b_req_ready", 32'(req_ready_b), 32'd1);
    check("rst_b_busy", 32'(busy_b), 32'd0);

    // Single-cycle latency, everything always ready: loads of word 0 then word 1.
    req_valid_b = 1'b1; req_addr_b = 32'd0; rsp_ready_b = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid_b) begin
        rsp_at.push_back(c);
        rsp_dat.push_back(rsp_rdata_b);
      end
      acc_now = req_ready_b && req_valid_b;
      if (acc_now) acc.push_back(c);
      @(negedge clk);
      if (acc_now) begin
        req_addr_b = 32'd4;
        if (acc.size() == 2) req_valid_b = 1'b0;
      end
    end
    check("b_accepts", acc.size(), 2);
    check("b_responses", rsp_dat.size(), 2);
    if (acc.size() == 2) check("b_spacing", acc[1] - acc[0], 3);
    if (acc.size() == 2 && rsp_dat.size() == 2) begin
      check("b_lat0", rsp_at[0] - acc[0] - 1, 1);
      check("b_lat1", rsp_at[1] - acc[1] - 1, 1);
      check("b_rdata0", rsp_dat[0], 32'd0);
      check("b_rdata1", rsp_dat[1], 32'd19);
    end

    do_req(1'b0, 32'd40, 32'd0, 0, 1'b0);
    do_req(1'b1, 32'd84, 32'h0000_1234, 0, 1'b0);
    do_req(1'b0, 32'd84, 32'd0, 1, 1'b0);
    do_req(1'b0, 32'd6, 32'd0, 0, 1'b0);
    do_req(1'b1, 32'd160, 32'hFFFF_FFFF, 0, 1'b0);
    do_req(1'b0, 32'd156, 32'd0, 0, 1'b0);
    do_req(1'b0, 32'd4, 32'd0, 5, 1'b1);
    do_req(1'b0, 32'd8, 32'd0, 0, 1'b0);

    // Store aborted by reset before its access edge.
    check("abort_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd88; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_req_ready_rst", 32'(req_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rdata", rsp_rdata, 32'd0);
    check("abort_err", 32'(rsp_err), 32'd0);
    check("abort_busy_rst", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_req(1'b0, 32'd88, 32'd0, 0, 1'b0);
    do_req(1'b0, 32'd84, 32'd0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, DEPTH + 1)) << 2;
        6:                a = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'd1;
        default:          a = $urandom;
      endcase
      do_req(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
